// File: rtl/key_conditioner.sv
// Multi-channel key/switch conditioner: polarity normalise, 2-FF sync, stability debounce,
// stretched press/release pulses and optional auto-repeat per channel.
module key_conditioner #(
  parameter int unsigned      WIDTH         = 2,
  parameter logic [WIDTH-1:0] ACTIVE_LOW    = '1,
  parameter int unsigned      TIMEOUT       = 50000,
  parameter int unsigned      TIMEOUT_WIDTH = 16,
  parameter int unsigned      PULSE_EXT     = 1,
  parameter bit               REPEAT_EN     = 1'b0,
  parameter int unsigned      REPEAT_DELAY  = 25000000,
  parameter int unsigned      REPEAT_PERIOD = 5000000,
  parameter int unsigned      REPEAT_WIDTH  = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] press_o,
  output logic [WIDTH-1:0] release_o,
  output logic [WIDTH-1:0] repeat_o,
  output logic             any_event_o
);

  localparam int unsigned PulseW = (PULSE_EXT > 1) ? $clog2(PULSE_EXT) : 1;

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rep_state_e;

  logic [WIDTH-1:0]         sync1_q, sync2_q;
  logic [WIDTH-1:0]         level_q, level_d;
  logic [WIDTH-1:0]         press_q, press_d;
  logic [WIDTH-1:0]         release_q, release_d;
  logic [WIDTH-1:0]         repeat_q, repeat_d;
  logic                     any_q;
  logic [WIDTH-1:0]         tog, rise, fall;
  logic [TIMEOUT_WIDTH-1:0] cnt_q [WIDTH];
  logic [TIMEOUT_WIDTH-1:0] cnt_d [WIDTH];
  logic [PulseW-1:0]        pcnt_q [WIDTH];
  logic [PulseW-1:0]        pcnt_d [WIDTH];
  logic [REPEAT_WIDTH-1:0]  rcnt_q [WIDTH];
  logic [REPEAT_WIDTH-1:0]  rcnt_d [WIDTH];
  rep_state_e               st_q [WIDTH];
  rep_state_e               st_d [WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      any_q     <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i]  <= '0;
        pcnt_q[i] <= '0;
        rcnt_q[i] <= '0;
        st_q[i]   <= StIdle;
      end
    end else begin
      sync1_q   <= data_in ^ ACTIVE_LOW;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      any_q     <= |(press_q | release_q | repeat_q);
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        pcnt_q[i] <= pcnt_d[i];
        rcnt_q[i] <= rcnt_d[i];
        st_q[i]   <= st_d[i];
      end
    end
  end

  // Debounce: any sample matching the current level restarts the stability count.
  always_comb begin
    tog = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == TIMEOUT_WIDTH'(TIMEOUT - 1)) begin
          tog[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign level_d = level_q ^ tog;
  assign rise    = tog & ~level_q;
  assign fall    = tog & level_q;

  // A new edge reloads the stretch counter and cancels the opposite pulse.
  always_comb begin
    press_d   = press_q;
    release_d = release_q;
    for (int i = 0; i < WIDTH; i++) begin
      pcnt_d[i] = pcnt_q[i];
      if (rise[i]) begin
        press_d[i]   = 1'b1;
        release_d[i] = 1'b0;
        pcnt_d[i]    = PulseW'(PULSE_EXT - 1);
      end else if (fall[i]) begin
        press_d[i]   = 1'b0;
        release_d[i] = 1'b1;
        pcnt_d[i]    = PulseW'(PULSE_EXT - 1);
      end else if (pcnt_q[i] != '0) begin
        pcnt_d[i] = pcnt_q[i] - 1'b1;
      end else begin
        press_d[i]   = 1'b0;
        release_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    repeat_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      st_d[i]   = st_q[i];
      rcnt_d[i] = rcnt_q[i];
      if (!REPEAT_EN || fall[i]) begin
        st_d[i]   = StIdle;
        rcnt_d[i] = '0;
      end else begin
        case (st_q[i])
          StIdle: begin
            if (rise[i]) begin
              st_d[i]   = StDelay;
              rcnt_d[i] = '0;
            end
          end
          StDelay: begin
            if (rcnt_q[i] == REPEAT_WIDTH'(REPEAT_DELAY - 1)) begin
              repeat_d[i] = 1'b1;
              rcnt_d[i]   = '0;
              st_d[i]     = StRepeat;
            end else begin
              rcnt_d[i] = rcnt_q[i] + 1'b1;
            end
          end
          StRepeat: begin
            if (rcnt_q[i] == REPEAT_WIDTH'(REPEAT_PERIOD - 1)) begin
              repeat_d[i] = 1'b1;
              rcnt_d[i]   = '0;
            end else begin
              rcnt_d[i] = rcnt_q[i] + 1'b1;
            end
          end
          default: begin
            st_d[i]   = StIdle;
            rcnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  assign level_o     = level_q;
  assign press_o     = press_q;
  assign release_o   = release_q;
  assign repeat_o    = repeat_q;
  assign any_event_o = any_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: ch0 active-low, ch1 active-high; a second instance
// with auto-repeat disabled shares the stimulus.
module tb_key_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] data_in;
  logic [1:0] level, press, rel, rep;
  logic       any_ev;
  logic [1:0] level2, press2, rel2, rep2;
  logic       any_ev2;
  logic       rep2_seen = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int cur   = 0;

  always #5 clk = ~clk;

  key_conditioner #(
    .WIDTH(2), .ACTIVE_LOW(2'b01), .TIMEOUT(8), .TIMEOUT_WIDTH(4), .PULSE_EXT(3),
    .REPEAT_EN(1'b1), .REPEAT_DELAY(20), .REPEAT_PERIOD(6), .REPEAT_WIDTH(5)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .level_o(level), .press_o(press),
    .release_o(rel), .repeat_o(rep), .any_event_o(any_ev)
  );

  key_conditioner #(
    .WIDTH(2), .ACTIVE_LOW(2'b01), .TIMEOUT(8), .TIMEOUT_WIDTH(4), .PULSE_EXT(3),
    .REPEAT_EN(1'b0), .REPEAT_DELAY(20), .REPEAT_PERIOD(6), .REPEAT_WIDTH(5)
  ) dut_norep (
    .clk(clk), .rst(rst), .data_in(data_in), .level_o(level2), .press_o(press2),
    .release_o(rel2), .repeat_o(rep2), .any_event_o(any_ev2)
  );

  always @(negedge clk) if (rep2 != 2'b00) rep2_seen = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cur++;
  endtask

  // Advance to 1 time unit after relative edge e.
  task automatic run_to(input int e);
    while (cur < e) tick();
  endtask

  // Marks the current edge as relative edge 0.
  task automatic mark();
    cur = 0;
  endtask

  initial begin
    rst     = 1'b1;
    data_in = 2'b01;
    repeat (3) tick();
    chk("rst_level", level, 2'b00);
    chk("rst_press", press, 2'b00);
    chk("rst_any", any_ev, 1'b0);
    rst = 1'b0;
    repeat (15) tick();
    chk("post_rst_level", level, 2'b00);
    chk("post_rst_press", press, 2'b00);
    chk("post_rst_any", any_ev, 1'b0);

    // Both channels pressed together and held; auto-repeat on both.
    mark();
    data_in = 2'b10;
    run_to(9);
    chk("press_e9_level", level, 2'b00);
    chk("press_e9_press", press, 2'b00);
    run_to(10);
    chk("press_e10_level", level, 2'b11);
    chk("press_e10_press", press, 2'b11);
    chk("press_e10_any", any_ev, 1'b0);
    chk("norep_e10_level", level2, 2'b11);
    run_to(11);
    chk("press_e11_any", any_ev, 1'b1);
    run_to(12);
    chk("press_e12_press", press, 2'b11);
    run_to(13);
    chk("press_e13_press", press, 2'b00);
    chk("press_e13_any", any_ev, 1'b1);
    run_to(14);
    chk("press_e14_any", any_ev, 1'b0);
    run_to(29);
    chk("rep_e29", rep, 2'b00);
    run_to(30);
    chk("rep_e30", rep, 2'b11);
    chk("rep_e30_press", press, 2'b00);
    run_to(31);
    chk("rep_e31", rep, 2'b00);
    chk("rep_e31_any", any_ev, 1'b1);
    run_to(36);
    chk("rep_e36", rep, 2'b11);
    run_to(42);
    chk("rep_e42", rep, 2'b11);

    // Release ch0 after edge 43: level falls at 53, ch1 keeps repeating.
    run_to(43);
    data_in = 2'b11;
    run_to(48);
    chk("rep_e48", rep, 2'b11);
    run_to(52);
    chk("rel_e52_level", level, 2'b11);
    run_to(53);
    chk("rel_e53_level", level, 2'b10);
    chk("rel_e53_rel", rel, 2'b01);
    chk("rel_e53_rep", rep, 2'b00);
    run_to(54);
    chk("rel_e54_rep", rep, 2'b10);
    run_to(55);
    chk("rel_e55_rel", rel, 2'b01);
    run_to(57);
    chk("rel_e57_rel", rel, 2'b00);
    run_to(60);
    chk("rep_e60", rep, 2'b10);
    data_in = 2'b01;
    run_to(66);
    chk("rep_e66", rep, 2'b10);
    run_to(70);
    chk("rel1_e70_level", level, 2'b00);
    chk("rel1_e70_rel", rel, 2'b10);
    chk("rel1_e70_press", press, 2'b00);
    run_to(72);
    chk("rel1_e72_rep", rep, 2'b00);
    run_to(80);

    // Seven-cycle glitch on ch0 is rejected.
    mark();
    data_in = 2'b00;
    run_to(7);
    data_in = 2'b01;
    run_to(10);
    chk("glitch_e10_level", level, 2'b00);
    chk("glitch_e10_press", press, 2'b00);
    run_to(12);
    chk("glitch_e12_level", level, 2'b00);
    chk("glitch_e12_any", any_ev, 1'b0);
    run_to(20);

    // Reset in the middle of a press pulse; pin stays active through reset.
    mark();
    data_in = 2'b00;
    run_to(10);
    chk("rpress_e10", press, 2'b01);
    run_to(11);
    rst = 1'b1;
    #1;
    chk("rst_mid_level", level, 2'b00);
    chk("rst_mid_press", press, 2'b00);
    chk("rst_mid_any", any_ev, 1'b0);
    run_to(15);
    rst = 1'b0;
    run_to(16);
    chk("rst_rel_e16_press", press, 2'b00);
    chk("rst_rel_e16_any", any_ev, 1'b0);
    run_to(24);
    chk("rst_rel_e24_level", level, 2'b00);
    run_to(25);
    chk("rst_rel_e25_level", level, 2'b01);
    chk("rst_rel_e25_press", press, 2'b01);
    run_to(26);
    chk("rst_rel_e26_any", any_ev, 1'b1);
    run_to(60);
    chk("norep_never", rep2_seen, 1'b0);
    chk("norep_level", level2, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
